mccp_host_loader: RTL and testbench
===================================

# mccp_host_loader

Host-side Avalon-MM initiator that boots the MCCP videocard without a testbench or HPS software in the loop. On `start` it copies a program image and an initial data image from a local word ROM into the videocard's shared memory, writes the control register to launch the cores, and polls status until the run completes. It can optionally read a result window back out as a valid/ready stream. It sits between the board-level boot logic and `videocard_top`, driving that block's `address/data_in/write/read` and `*_control` slave ports.

## Interface
- `WIDTH`, 32, data word width.
- `ADDR_W`, 17, memory address width (`WIDTH/2+1`).
- `PROG_BASE`, 65536, memory address of the first program word.
- `DATA_BASE`, 0, memory address of the first data word.
- `LEN_W`, 16, width of all length fields and counters.
- `POLL_MAX`, 65535, poll reads before timeout.

- `clk` in 1: system clock.
- `reset_sink_reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; ignored unless IDLE.
- `prog_len`, `data_len`, `rd_len` in `LEN_W` each: word counts, latched on `start`.
- `rom_address` out `LEN_W`: source ROM word address.
- `rom_data` in `WIDTH`: ROM word, valid one cycle after `rom_address`.
- `mem_address` out `ADDR_W`, `mem_writedata` out `WIDTH`, `mem_write` out 1, `mem_read` out 1: memory master.
- `mem_readdata` in `WIDTH`: valid one cycle after an accepted read.
- `mem_waitrequest` in 1: when high, hold the current command.
- `ctl_address` out 1, `ctl_writedata` out `WIDTH`, `ctl_write` out 1, `ctl_read` out 1: control master.
- `ctl_readdata` in `WIDTH`: valid the cycle after `ctl_read`.
- `res_data` out `WIDTH`, `res_valid` out 1, `res_ready` in 1: result stream.
- `busy` out 1, `done` out 1 (one-cycle pulse), `timeout` out 1 (sticky until next `start`).

## Operation
- States: IDLE, FETCH, WRITE, KICK, POLL_REQ, POLL_WAIT, RD_REQ, RD_WAIT, RD_OUT, DONE.
- `start` in IDLE latches the lengths, clears `timeout`, sets `busy`, and enters the program phase.
- Program phase, word i = 0..prog_len-1:
  - FETCH drives `rom_address=i`.
  - WRITE drives `mem_address=PROG_BASE+i`, `mem_writedata=rom_data`, `mem_write=1`.
  - The command is held while `mem_waitrequest` is high.
- Data phase: same sequence with `rom_address=prog_len+j` and `mem_address=DATA_BASE+j`, for j = 0..data_len-1.
- A phase with length 0 is skipped with no bus cycles.
- KICK: one cycle with `ctl_write=1`, `ctl_address=0`, `ctl_writedata=1`.
- Poll:
  - POLL_REQ drives `ctl_read=1`, `ctl_address=1`.
  - POLL_WAIT samples `ctl_readdata[0]` (busy).
  - If the bit is 1, return to POLL_REQ and increment the poll counter.
  - If the bit is 0, go to the readback phase.
  - When the counter reaches `POLL_MAX`, set `timeout` and go to DONE; no readback.
- Readback, k = 0..rd_len-1:
  - RD_REQ drives `mem_read=1`, `mem_address=DATA_BASE+k`, held while `mem_waitrequest` is high.
  - RD_WAIT captures `mem_readdata` into `res_data`.
  - RD_OUT asserts `res_valid` until `res_ready`, then advances.
- DONE: pulse `done` for one cycle, clear `busy`, return to IDLE.
- Address arithmetic is `ADDR_W`-bit and wraps modulo 2^`ADDR_W`; no range check.
- Reset mid-operation aborts immediately. No partial command completes after the reset cycle.

## Timing
- Reset values: all outputs 0 (`mem_*`, `ctl_*`, `rom_address`, `res_*`, `busy`, `done`, `timeout`); state IDLE.
- Minimum 2 cycles per loaded word with no waitrequest; each waitrequest cycle adds one.
- KICK is exactly 1 cycle. One poll iteration is 2 cycles.
- Readback takes a minimum of 3 cycles per word with `res_ready` held high.
- `res_data` is stable while `res_valid` is high and `res_ready` is low.
- `busy` rises the cycle after `start` and falls in the cycle `done` pulses.
- `start` while busy is ignored. `start` in the same cycle as reset is ignored.
- Only one of `mem_write`, `mem_read`, `ctl_write`, `ctl_read` is high in any cycle.

## Configuration
- `MCCP_LOADER_READBACK_EN` defined:
  - Readback states exist.
  - `res_*` behave as above.
- `MCCP_LOADER_READBACK_EN` undefined:
  - POLL_WAIT with status 0 goes directly to DONE.
  - `res_valid` and `res_data` are tied to 0; `rd_len` is ignored.

## Test plan
- Load program: `prog_len=62`, `data_len=6`, ROM words 0..61 = program image, 62..67 = {4,2,3,4,5,6}, no waitrequest, status clear on first poll -> memory at 65536..65597 and 0..5 matches ROM; exactly one KICK of value 1 at control address 0; `done` 1 pulse.
- Backpressure: `mem_waitrequest` high for 3 cycles on word 10 -> address and data held constant for 4 cycles; no word dropped or duplicated.
- Zero lengths: `prog_len=0`, `data_len=0` -> first bus cycle after `start` is the KICK.
- Polling: status busy for 5 reads, then clear -> 6 control reads, no timeout. Status stuck at 1 with `POLL_MAX=8` -> `timeout=1`, `done` pulses, no readback.
- Readback (`MCCP_LOADER_READBACK_EN`): `rd_len=15`, memory k holds k*3, `res_ready` toggling 1/0 -> 15 beats of values 0,3,…,42 in order, each held while not ready.
- Reset during data phase at word 3 -> next cycle all outputs 0 and IDLE; a new `start` reloads from word 0.

Source files
------------

// File: rtl/mccp_host_loader_if.sv
// mccp_host_loader_if
//   Avalon-MM bundle between the host loader and videocard_top.
//   Memory master: mem_address/mem_writedata/mem_write/mem_read out,
//                  mem_readdata/mem_waitrequest in.
//   Control master: ctl_address/ctl_writedata/ctl_write/ctl_read out,
//                   ctl_readdata in.
interface mccp_host_loader_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 17
);
    logic [ADDR_W-1:0] mem_address;
    logic [WIDTH-1:0]  mem_writedata;
    logic              mem_write;
    logic              mem_read;
    logic [WIDTH-1:0]  mem_readdata;
    logic              mem_waitrequest;
    logic              ctl_address;
    logic [WIDTH-1:0]  ctl_writedata;
    logic              ctl_write;
    logic              ctl_read;
    logic [WIDTH-1:0]  ctl_readdata;

    modport master (
        output mem_address, mem_writedata, mem_write, mem_read,
        input  mem_readdata, mem_waitrequest,
        output ctl_address, ctl_writedata, ctl_write, ctl_read,
        input  ctl_readdata
    );

    modport slave (
        input  mem_address, mem_writedata, mem_write, mem_read,
        output mem_readdata, mem_waitrequest,
        input  ctl_address, ctl_writedata, ctl_write, ctl_read,
        output ctl_readdata
    );
endinterface

// File: rtl/mccp_host_loader.sv
// mccp_host_loader
//   Boots the MCCP videocard: copies program and data images from a local
//   word ROM into shared memory, kicks the cores, polls status until idle and
//   optionally streams a result window back out.
//   Ports: clk, reset_sink_reset (sync, active high), start, prog_len,
//          data_len, rd_len, rom_address/rom_data (ROM, 1-cycle latency),
//          bus (memory + control Avalon-MM master), res_data/res_valid/
//          res_ready (result stream), busy, done, timeout.
//   Optional feature macro: MCCP_LOADER_READBACK_EN enables the readback
//   phase; without it res_* are tied low and rd_len is ignored.
module mccp_host_loader #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned PROG_BASE = 65536,
    parameter int unsigned DATA_BASE = 0,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned POLL_MAX  = 65535
) (
    input  logic               clk,
    input  logic               reset_sink_reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   prog_len,
    input  logic [LEN_W-1:0]   data_len,
    input  logic [LEN_W-1:0]   rd_len,
    output logic [LEN_W-1:0]   rom_address,
    input  logic [WIDTH-1:0]   rom_data,
    mccp_host_loader_if.master bus,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WRITE, S_KICK, S_POLL_REQ, S_POLL_WAIT,
        S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic               phase_q, phase_d;       // 0: program image, 1: data image
    logic [LEN_W-1:0]   poll_q, poll_d;
    logic [LEN_W-1:0]   prog_len_q, prog_len_d;
    logic [LEN_W-1:0]   data_len_q, data_len_d;
    logic               timeout_q, timeout_d;
    logic [LEN_W-1:0]   rom_address_q, rom_address_d;
    logic [ADDR_W-1:0]  mem_address_q, mem_address_d;
    logic               mem_write_q, mem_write_d;
    logic               mem_read_q, mem_read_d;
    logic               ctl_address_q, ctl_address_d;
    logic [WIDTH-1:0]   ctl_writedata_q, ctl_writedata_d;
    logic               ctl_write_q, ctl_write_d;
    logic               ctl_read_q, ctl_read_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   cur_len;
    logic [LEN_W-1:0]   idx_inc;
`ifdef MCCP_LOADER_READBACK_EN
    logic [LEN_W-1:0]   rd_len_q, rd_len_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_valid_q, res_valid_d;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset_sink_reset) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            phase_q         <= 1'b0;
            poll_q          <= '0;
            prog_len_q      <= '0;
            data_len_q      <= '0;
            timeout_q       <= 1'b0;
            rom_address_q   <= '0;
            mem_address_q   <= '0;
            mem_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            ctl_address_q   <= 1'b0;
            ctl_writedata_q <= '0;
            ctl_write_q     <= 1'b0;
            ctl_read_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
`ifdef MCCP_LOADER_READBACK_EN
            rd_len_q        <= '0;
            res_data_q      <= '0;
            res_valid_q     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            phase_q         <= phase_d;
            poll_q          <= poll_d;
            prog_len_q      <= prog_len_d;
            data_len_q      <= data_len_d;
            timeout_q       <= timeout_d;
            rom_address_q   <= rom_address_d;
            mem_address_q   <= mem_address_d;
            mem_write_q     <= mem_write_d;
            mem_read_q      <= mem_read_d;
            ctl_address_q   <= ctl_address_d;
            ctl_writedata_q <= ctl_writedata_d;
            ctl_write_q     <= ctl_write_d;
            ctl_read_q      <= ctl_read_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
`ifdef MCCP_LOADER_READBACK_EN
            rd_len_q        <= rd_len_d;
            res_data_q      <= res_data_d;
            res_valid_q     <= res_valid_d;
`endif
        end
    end

    // Next state, counters, and output values for the state being entered
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        poll_d     = poll_q;
        prog_len_d = prog_len_q;
        data_len_d = data_len_q;
        timeout_d  = timeout_q;
`ifdef MCCP_LOADER_READBACK_EN
        rd_len_d   = rd_len_q;
        res_data_d = res_data_q;
`endif
        cur_len    = phase_q ? data_len_q : prog_len_q;
        idx_inc    = idx_q + LEN_W'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    prog_len_d = prog_len;
                    data_len_d = data_len;
`ifdef MCCP_LOADER_READBACK_EN
                    rd_len_d   = rd_len;
`endif
                    timeout_d  = 1'b0;
                    poll_d     = '0;
                    idx_d      = '0;
                    // an empty program image starts straight in the data image
                    phase_d    = (prog_len == '0);
                    state_d    = (prog_len == '0 && data_len == '0) ? S_KICK : S_FETCH;
                end
            end
            S_FETCH: state_d = S_WRITE;
            S_WRITE: begin
                if (!bus.mem_waitrequest) begin
                    if (idx_inc != cur_len) begin
                        idx_d   = idx_inc;
                        state_d = S_FETCH;
                    end else if (!phase_q && data_len_q != '0) begin
                        phase_d = 1'b1;
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_KICK;
                    end
                end
            end
            S_KICK:     state_d = S_POLL_REQ;
            S_POLL_REQ: state_d = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (bus.ctl_readdata[0]) begin
                    if (poll_q == LEN_W'(POLL_MAX - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        poll_d  = poll_q + LEN_W'(1);
                        state_d = S_POLL_REQ;
                    end
                end else begin
`ifdef MCCP_LOADER_READBACK_EN
                    idx_d   = '0;
                    state_d = (rd_len_q == '0) ? S_DONE : S_RD_REQ;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MCCP_LOADER_READBACK_EN
            S_RD_REQ: begin
                if (!bus.mem_waitrequest) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                res_data_d = bus.mem_readdata;
                state_d    = S_RD_OUT;
            end
            S_RD_OUT: begin
                if (res_ready) begin
                    if (idx_inc == rd_len_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = S_RD_REQ;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // rom_address holds through WRITE so rom_data stays valid under waitrequest
        rom_address_d = rom_address_q;
        if (state_d == S_FETCH)
            rom_address_d = phase_d ? prog_len_d + idx_d : idx_d;

        mem_address_d = '0;
        if (state_d == S_WRITE)
            mem_address_d = (phase_d ? ADDR_W'(DATA_BASE) : ADDR_W'(PROG_BASE)) + ADDR_W'(idx_d);
        else if (state_d == S_RD_REQ)
            mem_address_d = ADDR_W'(DATA_BASE) + ADDR_W'(idx_d);

        mem_write_d     = (state_d == S_WRITE);
        mem_read_d      = (state_d == S_RD_REQ);
        ctl_write_d     = (state_d == S_KICK);
        ctl_writedata_d = (state_d == S_KICK) ? WIDTH'(1) : '0;
        ctl_read_d      = (state_d == S_POLL_REQ);
        ctl_address_d   = (state_d == S_POLL_REQ);
        busy_d          = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d          = (state_d == S_DONE);
`ifdef MCCP_LOADER_READBACK_EN
        res_valid_d     = (state_d == S_RD_OUT);
`endif
    end

    assign rom_address       = rom_address_q;
    assign bus.mem_address   = mem_address_q;
    // ROM has one cycle of latency, so its word is forwarded during WRITE
    assign bus.mem_writedata = mem_write_q ? rom_data : '0;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_read      = mem_read_q;
    assign bus.ctl_address   = ctl_address_q;
    assign bus.ctl_writedata = ctl_writedata_q;
    assign bus.ctl_write     = ctl_write_q;
    assign bus.ctl_read      = ctl_read_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign timeout           = timeout_q;

`ifdef MCCP_LOADER_READBACK_EN
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;

    logic unused_c;
    assign unused_c = ^bus.ctl_readdata[WIDTH-1:1];
`else
    assign res_data  = '0;
    assign res_valid = 1'b0;

    logic unused_c;
    assign unused_c = ^{bus.ctl_readdata[WIDTH-1:1], rd_len, res_ready, bus.mem_readdata};
`endif

endmodule

// File: tb/tb_mccp_host_loader.sv
// tb_mccp_host_loader: table-driven load/kick/poll runs against ROM, memory
// and control slave models, plus reset-abort and readback sequences.
module tb_mccp_host_loader;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned PROG_BASE = 65536;
    localparam int unsigned DATA_BASE = 0;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned POLL_MAX  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_sink_reset;
    logic               start;
    logic [LEN_W-1:0]   prog_len, data_len, rd_len;
    logic [LEN_W-1:0]   rom_address;
    logic [WIDTH-1:0]   rom_data;
    logic [WIDTH-1:0]   res_data;
    logic               res_valid;
    logic               res_ready;
    logic               busy, done, timeout;

    mccp_host_loader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    mccp_host_loader #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .PROG_BASE(PROG_BASE),
        .DATA_BASE(DATA_BASE), .LEN_W(LEN_W), .POLL_MAX(POLL_MAX)
    ) dut (
        .clk(clk), .reset_sink_reset(reset_sink_reset), .start(start),
        .prog_len(prog_len), .data_len(data_len), .rd_len(rd_len),
        .rom_address(rom_address), .rom_data(rom_data), .bus(bus),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done), .timeout(timeout)
    );

    // ---------------- slave models ----------------
    logic [WIDTH-1:0] rom_mem [0:255];
    int   busy_polls = 0;
    int   wait_word  = -1;
    int   wait_len   = 3;
    int   cfg_p      = 0;
    logic mon_clr    = 1'b0;
    logic tog_en     = 1'b0;
    int   ctl_resp   = 0;
    int   wait_seen  = 0;
    logic tog_q      = 1'b1;

    always @(posedge clk) begin
        rom_data <= rom_mem[rom_address[7:0]];
        if (bus.mem_read && !bus.mem_waitrequest)
            bus.mem_readdata <= WIDTH'(bus.mem_address) * 32'd3;
        if (mon_clr) begin
            ctl_resp  <= 0;
            wait_seen <= 0;
        end else begin
            if (bus.ctl_read) begin
                bus.ctl_readdata <= (ctl_resp < busy_polls) ? 32'd1 : 32'd0;
                ctl_resp         <= ctl_resp + 1;
            end
            if (bus.mem_waitrequest) wait_seen <= wait_seen + 1;
        end
        tog_q <= tog_en ? ~tog_q : 1'b1;
    end

    assign res_ready = tog_q;

    always_comb begin
        bus.mem_waitrequest = bus.mem_write && (wait_word >= 0) &&
                              (bus.mem_address == ADDR_W'(PROG_BASE + 32'(wait_word))) &&
                              (wait_seen < wait_len);
    end

    function automatic logic [ADDR_W-1:0] exp_addr(input int n, input int p);
        return (n < p) ? ADDR_W'(PROG_BASE + 32'(n)) : ADDR_W'(DATA_BASE + 32'(n - p));
    endfunction

    // ---------------- monitor ----------------
    int wr_seq, wr_bad, hold_cyc, hold_bad, kicks, kick_bad, ctl_rds, ctl_bad;
    int done_cnt, busy_cyc, onehot_bad, first_cmd, beats, beat_bad, stall_bad, valid_seen;
    logic              hold_prev, rv_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [WIDTH-1:0]  prev_data, rv_data;

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_seq <= 0; wr_bad <= 0; hold_cyc <= 0; hold_bad <= 0;
            kicks <= 0; kick_bad <= 0; ctl_rds <= 0; ctl_bad <= 0;
            done_cnt <= 0; busy_cyc <= 0; onehot_bad <= 0; first_cmd <= 0;
            beats <= 0; beat_bad <= 0; stall_bad <= 0; valid_seen <= 0;
            hold_prev <= 1'b0; rv_stall <= 1'b0;
        end else begin
            if ((int'(bus.mem_write) + int'(bus.mem_read) + int'(bus.ctl_write) + int'(bus.ctl_read)) > 1)
                onehot_bad <= onehot_bad + 1;
            if (first_cmd == 0 && (bus.mem_write || bus.mem_read || bus.ctl_write || bus.ctl_read))
                first_cmd <= bus.mem_write ? 1 : bus.mem_read ? 2 : bus.ctl_write ? 3 : 4;
            if (bus.mem_write) begin
                if (wait_word >= 0 && bus.mem_address == ADDR_W'(PROG_BASE + 32'(wait_word)))
                    hold_cyc <= hold_cyc + 1;
                if (hold_prev && (bus.mem_address != prev_addr || bus.mem_writedata != prev_data))
                    hold_bad <= hold_bad + 1;
                if (!bus.mem_waitrequest) begin
                    if (bus.mem_address != exp_addr(wr_seq, cfg_p) ||
                        bus.mem_writedata != rom_mem[wr_seq[7:0]])
                        wr_bad <= wr_bad + 1;
                    wr_seq <= wr_seq + 1;
                end
                hold_prev <= bus.mem_waitrequest;
                prev_addr <= bus.mem_address;
                prev_data <= bus.mem_writedata;
            end else begin
                if (hold_prev) hold_bad <= hold_bad + 1;
                hold_prev <= 1'b0;
            end
            if (bus.ctl_write) begin
                kicks <= kicks + 1;
                if (bus.ctl_address !== 1'b0 || bus.ctl_writedata !== 32'd1) kick_bad <= kick_bad + 1;
            end
            if (bus.ctl_read) begin
                ctl_rds <= ctl_rds + 1;
                if (bus.ctl_address !== 1'b1) ctl_bad <= ctl_bad + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (busy) busy_cyc <= busy_cyc + 1;
            if (res_valid) begin
                valid_seen <= valid_seen + 1;
                if (rv_stall && res_data != rv_data) stall_bad <= stall_bad + 1;
                if (res_ready) begin
                    if (res_data != WIDTH'(beats * 3)) beat_bad <= beat_bad + 1;
                    beats    <= beats + 1;
                    rv_stall <= 1'b0;
                end else begin
                    rv_stall <= 1'b1;
                    rv_data  <= res_data;
                end
            end else begin
                if (rv_stall) stall_bad <= stall_bad + 1;
                rv_stall <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs_set();
        return $countones({rom_address, bus.mem_address, bus.mem_writedata, bus.mem_write,
                           bus.mem_read, bus.ctl_address, bus.ctl_writedata, bus.ctl_write,
                           bus.ctl_read, res_data, res_valid, busy, done, timeout});
    endfunction

    task automatic launch(input int p, input int d, input int rd, input int polls,
                          input int wword, input int restart);
        @(posedge clk); #1;
        cfg_p      = p;
        busy_polls = polls;
        wait_word  = wword;
        mon_clr    = 1'b1;
        @(posedge clk); #1;
        mon_clr  = 1'b0;
        start    = 1'b1;
        prog_len = LEN_W'(p);
        data_len = LEN_W'(d);
        rd_len   = LEN_W'(rd);
        @(posedge clk); #1;
        start = 1'b0;
        if (restart != 0) begin
            repeat (3) @(posedge clk);
            #1;
            start    = 1'b1;
            prog_len = LEN_W'(1);
            data_len = LEN_W'(1);
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_done: done not seen within 3000 cycles");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int p, d, rd, polls, wword, restart;
        int exp_writes, exp_hold, exp_reads, exp_tmo, exp_busy, exp_first;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok;
        bit seen;
        int dimg [6];

        dimg = '{4, 2, 3, 4, 5, 6};
        for (int i = 0; i < 256; i++) rom_mem[i] = 32'h5A00_0000 + 32'(i * 257);
        for (int i = 0; i < 6; i++) rom_mem[62 + i] = 32'(dimg[i]);

        //           p   d  rd polls wword rst | writes hold reads tmo busy first
        vecs[0] = '{62, 6,  0,    0,   -1,  1,     68,   0,    1,  0, 139,    1};
        vecs[1] = '{20, 4,  0,    0,   10,  0,     24,   4,    1,  0,  54,    1};
        vecs[2] = '{ 0, 0,  0,    0,   -1,  0,      0,   0,    1,  0,   3,    3};
        vecs[3] = '{ 3, 2,  0,    5,   -1,  0,      5,   0,    6,  0,  23,    1};
        vecs[4] = '{ 2, 0,  4, 1000,   -1,  0,      2,   0,    8,  1,  21,    1};
        vecs[5] = '{ 0, 3,  0,    1,   -1,  0,      3,   0,    2,  0,  11,    1};

        reset_sink_reset = 1'b1;
        start    = 1'b0;
        prog_len = '0;
        data_len = '0;
        rd_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs_set(), 0);
        reset_sink_reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            launch(vecs[v].p, vecs[v].d, vecs[v].rd, vecs[v].polls, vecs[v].wword, vecs[v].restart);
            wait_done(ok);
            check($sformatf("v%0d_writes", v),     wr_seq,     vecs[v].exp_writes);
            check($sformatf("v%0d_wr_order", v),   wr_bad,     0);
            check($sformatf("v%0d_hold_cyc", v),   hold_cyc,   vecs[v].exp_hold);
            check($sformatf("v%0d_hold_bad", v),   hold_bad,   0);
            check($sformatf("v%0d_kicks", v),      kicks,      1);
            check($sformatf("v%0d_kick_val", v),   kick_bad,   0);
            check($sformatf("v%0d_ctl_reads", v),  ctl_rds,    vecs[v].exp_reads);
            check($sformatf("v%0d_ctl_addr", v),   ctl_bad,    0);
            check($sformatf("v%0d_timeout", v),    timeout,    vecs[v].exp_tmo);
            check($sformatf("v%0d_done", v),       done_cnt,   1);
            check($sformatf("v%0d_busy_cyc", v),   busy_cyc,   vecs[v].exp_busy);
            check($sformatf("v%0d_busy_end", v),   busy,       0);
            check($sformatf("v%0d_onehot", v),     onehot_bad, 0);
            check($sformatf("v%0d_first_cmd", v),  first_cmd,  vecs[v].exp_first);
            check($sformatf("v%0d_res_valid", v),  valid_seen, 0);
        end

        // readback with res_ready toggling
        tog_en = 1'b1;
        launch(1, 0, 15, 0, -1, 0);
        wait_done(ok);
        tog_en = 1'b0;
        check("rb_writes", wr_seq, 1);
        check("rb_done", done_cnt, 1);
        check("rb_onehot", onehot_bad, 0);
`ifdef MCCP_LOADER_READBACK_EN
        check("rb_beats", beats, 15);
        check("rb_values", beat_bad, 0);
        check("rb_stable", stall_bad, 0);
`else
        check("rb_beats_off", beats, 0);
        check("rb_valid_off", valid_seen, 0);
        check("rb_busy_cyc", busy_cyc, 5);
`endif

        // reset while writing data word 3, start held during the reset cycle
        launch(5, 6, 0, 0, -1, 0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.mem_write && bus.mem_address == ADDR_W'(DATA_BASE + 3)) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("rst_reach_data3", seen, 1);
        reset_sink_reset = 1'b1;
        start            = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs", outs_set(), 0);
        reset_sink_reset = 1'b0;
        start            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stays_idle", outs_set(), 0);

        launch(5, 6, 0, 0, -1, 0);
        wait_done(ok);
        check("reload_writes", wr_seq, 11);
        check("reload_order", wr_bad, 0);
        check("reload_kicks", kicks, 1);
        check("reload_done", done_cnt, 1);
        check("reload_busy_cyc", busy_cyc, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
